// File: rtl/gf180mcu_tribus_pkg.sv
// Shared types and helpers for the tristate-bus receiver: FSM state encoding,
// glitch counter width and the even-parity helper.
package gf180mcu_tribus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    REL    = 2'd3
  } state_t;

  localparam int GCNT_W = 4;

  // Even parity of a word; narrower words are zero-extended by the caller.
  function automatic logic even_par(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/gf180mcu_tribus_fifo.sv
// Synchronous FIFO with simultaneous push/pop, async active-low reset on control.
// The head output falls back to the last popped word while the FIFO is empty.
module gf180mcu_tribus_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RN,
  input  logic                     push_req,
  input  logic                     pop_req,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_nxt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [W-1:0]  last_q;
  logic          push, pop;

  assign count     = wr_ptr - rd_ptr;
  assign full      = (count == PW'(DEPTH));
  assign empty     = (count == '0);
  assign pop       = pop_req && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign push      = push_req && (!full || pop);
  assign count_nxt = count + PW'(push) - PW'(pop);
  assign rdata     = empty ? last_q : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        last_q <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/gf180mcu_tribus_rx.sv
// Tristate bus receiver: settle, capture one re-inverted word per drive window,
// keep it and queue it. Optional parity check enabled by TRIBUS_RX_PARITY_EN.
module gf180mcu_tribus_rx
  import gf180mcu_tribus_pkg::*;
#(
  parameter int W          = 8,
  parameter int DEPTH      = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic              CLK,
  input  logic              RN,
  input  logic [W-1:0]      BUS_ZN,
  input  logic              DRV,
`ifdef TRIBUS_RX_PARITY_EN
  input  logic              BUS_PZN,
  output logic              PERR,
`endif
  output logic              BUSY,
  output logic [W-1:0]      KEEP,
  output logic [W-1:0]      O_DATA,
  output logic              O_VLD,
  input  logic              O_RDY,
  output logic [GCNT_W-1:0] GLITCH_CNT,
  output logic              OVF
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int CNT_W = 4;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             glitch_hit, sample, par_bad, push_req;
  logic             full, empty, fifo_pop;
  logic [PW-1:0]    count, count_nxt;
  logic [W-1:0]     word;

  function automatic logic [GCNT_W-1:0] sat_inc(input logic [GCNT_W-1:0] v);
    return (&v) ? v : v + GCNT_W'(1);
  endfunction

  assign word = ~BUS_ZN;

`ifdef TRIBUS_RX_PARITY_EN
  assign par_bad = (even_par(64'(word)) != ~BUS_PZN);
`else
  assign par_bad = 1'b0;
`endif

  assign push_req = sample && !par_bad;
  assign fifo_pop = O_RDY && !empty;
  assign O_VLD    = !empty;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    glitch_hit = 1'b0;
    sample     = 1'b0;
    case (state_q)
      IDLE: begin
        if (DRV) begin
          state_d = SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYC - 1);
        end
      end
      SETTLE: begin
        if (!DRV) begin
          glitch_hit = 1'b1;
          state_d    = IDLE;
        end else if (cnt_q == '0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SAMPLE: begin
        sample  = 1'b1;
        state_d = REL;
      end
      REL: begin
        if (!DRV) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and captured-state registers
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      KEEP       <= '0;
      GLITCH_CNT <= '0;
      OVF        <= 1'b0;
      BUSY       <= 1'b0;
`ifdef TRIBUS_RX_PARITY_EN
      PERR       <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      BUSY    <= (count_nxt >= PW'(DEPTH - 1));
      if (push_req) KEEP <= word;
      if (glitch_hit) GLITCH_CNT <= sat_inc(GLITCH_CNT);
      if (push_req && full && !fifo_pop) OVF <= 1'b1;
`ifdef TRIBUS_RX_PARITY_EN
      if (sample && par_bad) PERR <= 1'b1;
`endif
    end
  end

  gf180mcu_tribus_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RN        (RN),
    .push_req  (push_req),
    .pop_req   (O_RDY),
    .wdata     (word),
    .rdata     (O_DATA),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .count_nxt (count_nxt)
  );

endmodule

// File: tb/tb_gf180mcu_tribus_rx.sv
// Scoreboard bench for gf180mcu_tribus_rx: directed drive windows, with a
// monitor that pops expected words whenever the DUT hands one over.
module tb_gf180mcu_tribus_rx;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RN = 1'b0;
  logic [W-1:0] BUS_ZN = '0;
  logic         DRV = 1'b0;
  logic         O_RDY = 1'b0;
  logic         BUSY;
  logic [W-1:0] KEEP, O_DATA;
  logic         O_VLD;
  logic [3:0]   GLITCH_CNT;
  logic         OVF;
`ifdef TRIBUS_RX_PARITY_EN
  logic         BUS_PZN = 1'b0;
  logic         PERR;
`endif

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_e;

  always #5 CLK = ~CLK;

  gf180mcu_tribus_rx #(.W(W), .DEPTH(4), .SETTLE_CYC(2)) dut (
    .CLK        (CLK),
    .RN         (RN),
    .BUS_ZN     (BUS_ZN),
    .DRV        (DRV),
`ifdef TRIBUS_RX_PARITY_EN
    .BUS_PZN    (BUS_PZN),
    .PERR       (PERR),
`endif
    .BUSY       (BUSY),
    .KEEP       (KEEP),
    .O_DATA     (O_DATA),
    .O_VLD      (O_VLD),
    .O_RDY      (O_RDY),
    .GLITCH_CNT (GLITCH_CNT),
    .OVF        (OVF)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RN && O_VLD && O_RDY) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=0x%0h expected=none", O_DATA);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_data", 32'(O_DATA), 32'(sb_e));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic window(input logic [W-1:0] zn, input int hi);
    BUS_ZN = zn;
    DRV = 1'b1;
    repeat (hi) tick();
    DRV = 1'b0;
    tick();
    tick();
  endtask

  task automatic drain();
    int n = 0;
    O_RDY = 1'b1;
    while (O_VLD && n < 20) begin
      tick();
      n++;
    end
    O_RDY = 1'b0;
    check("drain_done", 32'(O_VLD), 32'(0));
    check("sb_empty", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_vld", 32'(O_VLD), 32'(0));
    check("rst_keep", 32'(KEEP), 32'(0));
    check("rst_data", 32'(O_DATA), 32'(0));
    check("rst_busy", 32'(BUSY), 32'(0));
    check("rst_glitch", 32'(GLITCH_CNT), 32'(0));
    check("rst_ovf", 32'(OVF), 32'(0));
    RN = 1'b1;
    tick();

    // basic capture and latency
    BUS_ZN = 8'h5A;
    DRV = 1'b1;
    tick(); tick(); tick();
    check("lat_vld_early", 32'(O_VLD), 32'(0));
    tick();
    check("lat_vld", 32'(O_VLD), 32'(1));
    check("basic_keep", 32'(KEEP), 32'hA5);
    check("basic_data", 32'(O_DATA), 32'hA5);
    exp_q.push_back(8'hA5);
    tick(); tick();
    DRV = 1'b0;
    tick(); tick();
    check("basic_busy", 32'(BUSY), 32'(0));
    drain();

    // glitches
    for (int i = 0; i < 20; i++) begin
      DRV = 1'b1;
      tick();
      DRV = 1'b0;
      tick();
      if (i == 0) check("glitch_one", 32'(GLITCH_CNT), 32'(1));
    end
    check("glitch_sat", 32'(GLITCH_CNT), 32'd15);
    check("glitch_keep", 32'(KEEP), 32'hA5);
    check("glitch_nopush", 32'(O_VLD), 32'(0));

    // fill and overflow
    for (int i = 0; i < 5; i++) begin
      v = 8'(8'hFE - i);
      window(v, 6);
      if (i < 4) exp_q.push_back(~v);
      if (i == 1) check("busy_after2", 32'(BUSY), 32'(0));
      if (i == 2) check("busy_after3", 32'(BUSY), 32'(1));
    end
    check("ovf_set", 32'(OVF), 32'(1));
    check("ovf_keep", 32'(KEEP), 32'h05);
    check("ovf_head", 32'(O_DATA), 32'h01);
    drain();
    check("busy_drained", 32'(BUSY), 32'(0));

    // reset mid-window, then DRV still high at release
    BUS_ZN = 8'h3C;
    DRV = 1'b1;
    tick();
    #2;
    RN = 1'b0;
    #1;
    check("mrst_keep", 32'(KEEP), 32'(0));
    check("mrst_glitch", 32'(GLITCH_CNT), 32'(0));
    check("mrst_ovf", 32'(OVF), 32'(0));
    check("mrst_vld", 32'(O_VLD), 32'(0));
    check("mrst_data", 32'(O_DATA), 32'(0));
    check("mrst_busy", 32'(BUSY), 32'(0));
    tick();
    RN = 1'b1;
    tick(); tick(); tick();
    check("mrst_vld_early", 32'(O_VLD), 32'(0));
    tick();
    check("mrst_capture", 32'(O_VLD), 32'(1));
    check("mrst_keep2", 32'(KEEP), 32'hC3);
    exp_q.push_back(8'hC3);
    DRV = 1'b0;
    tick(); tick();
    drain();

    // full FIFO with simultaneous pop in the SAMPLE cycle
    for (int i = 0; i < 4; i++) begin
      v = 8'((i + 1) * 8'h11);
      window(~v, 6);
      exp_q.push_back(v);
    end
    check("full_busy", 32'(BUSY), 32'(1));
    BUS_ZN = ~8'h55;
    DRV = 1'b1;
    tick(); tick(); tick();
    O_RDY = 1'b1;
    tick();
    O_RDY = 1'b0;
    exp_q.push_back(8'h55);
    check("fpop_ovf", 32'(OVF), 32'(0));
    check("fpop_busy", 32'(BUSY), 32'(1));
    check("fpop_keep", 32'(KEEP), 32'h55);
    check("fpop_head", 32'(O_DATA), 32'h22);
    tick(); tick();
    DRV = 1'b0;
    tick(); tick();
    drain();

`ifdef TRIBUS_RX_PARITY_EN
    BUS_PZN = 1'b1;
    window(8'hFE, 6);
    check("par_err", 32'(PERR), 32'(1));
    check("par_nopush", 32'(O_VLD), 32'(0));
    check("par_keep", 32'(KEEP), 32'h55);
    BUS_PZN = 1'b0;
    window(8'hFE, 6);
    exp_q.push_back(8'h01);
    check("par_ok_keep", 32'(KEEP), 32'h01);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
